// File: rtl/pe_feeder_pkg.sv
// Shared constants and state encoding for the GLB-side PE array feeder.
package pe_feeder_pkg;

    localparam int unsigned DefDataBits = 16;
    localparam int unsigned DefXidBits  = 5;
    localparam int unsigned DefYidBits  = 5;
    localparam int unsigned DefAddrBits = 14;
    localparam int unsigned DefLenBits  = 8;
    localparam int unsigned DefPassBits = 6;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StFilt = 3'd1;
    localparam logic [2:0] StIf3  = 3'd2;
    localparam logic [2:0] StIp   = 3'd3;
    localparam logic [2:0] StOp   = 3'd4;
    localparam logic [2:0] StIf1  = 3'd5;
    localparam logic [2:0] StFin  = 3'd6;

    function automatic logic is_feed(input logic [2:0] st);
        return (st == StFilt) || (st == StIf3) || (st == StIp) || (st == StIf1);
    endfunction

endpackage

// File: rtl/glb_rd_skid.sv
// Two-entry FIFO between the SRAM read port and the PE array data bus.
module glb_rd_skid #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             empty_o,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = ~wr_ptr_q;
        if (pop_i)  rd_ptr_d = ~rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign empty_o = (cnt_q == 2'd0);
    assign count_o = cnt_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/pe_array_feeder.sv
// Streams filter/ifmap/ipsum words from GLB SRAM to the PE array with X/Y tags
// and writes returning opsums back, sequencing FILT->IF3->(IP->OP->IF1)*.
module pe_array_feeder
    import pe_feeder_pkg::*;
#(
    parameter int unsigned DATA_BITS = DefDataBits,
    parameter int unsigned XID_BITS  = DefXidBits,
    parameter int unsigned YID_BITS  = DefYidBits,
    parameter int unsigned ADDR_BITS = DefAddrBits,
    parameter int unsigned LEN_BITS  = DefLenBits,
    parameter int unsigned PASS_BITS = DefPassBits
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    input  logic [XID_BITS-1:0]  cfg_tag_x_num,
    input  logic [YID_BITS-1:0]  cfg_tag_y_num,
    input  logic [LEN_BITS-1:0]  cfg_filt_len,
    input  logic [LEN_BITS-1:0]  cfg_if3_len,
    input  logic [LEN_BITS-1:0]  cfg_if1_len,
    input  logic [PASS_BITS-1:0] cfg_passes,
    input  logic [ADDR_BITS-1:0] cfg_filt_base,
    input  logic [ADDR_BITS-1:0] cfg_ifmap_base,
    input  logic [ADDR_BITS-1:0] cfg_ipsum_base,
    input  logic [ADDR_BITS-1:0] cfg_opsum_base,
    output logic                 mem_rd_en,
    output logic [ADDR_BITS-1:0] mem_rd_addr,
    input  logic [DATA_BITS-1:0] mem_rd_data,
    output logic                 mem_wr_en,
    output logic [ADDR_BITS-1:0] mem_wr_addr,
    output logic [DATA_BITS-1:0] mem_wr_data,
    output logic [DATA_BITS-1:0] pe_data_out,
    output logic                 filter_valid,
    input  logic                 filter_ready,
    output logic                 ifmap_valid,
    input  logic                 ifmap_ready,
    output logic                 ipsum_valid,
    input  logic                 ipsum_ready,
    output logic                 opsum_ready,
    input  logic                 opsum_valid,
    input  logic [DATA_BITS-1:0] pe_data_in,
    output logic [XID_BITS-1:0]  filter_tag_X,
    output logic [XID_BITS-1:0]  ifmap_tag_X,
    output logic [XID_BITS-1:0]  ipsum_tag_X,
    output logic [XID_BITS-1:0]  opsum_tag_X,
    output logic [YID_BITS-1:0]  filter_tag_Y,
    output logic [YID_BITS-1:0]  ifmap_tag_Y,
    output logic [YID_BITS-1:0]  ipsum_tag_Y,
    output logic [YID_BITS-1:0]  opsum_tag_Y,
    output logic                 ker_feed_done,
    output logic                 if3_feed_done,
    output logic                 ip_feed_done,
    output logic                 if1_feed_done,
    output logic                 op_get_done,
    output logic                 op_pass_done
);

    localparam int unsigned CNT_BITS = XID_BITS + YID_BITS + LEN_BITS;

    logic [2:0]           state_q, state_d;
    logic [XID_BITS-1:0]  x_num_q, x_q, x_d;
    logic [YID_BITS-1:0]  y_num_q, y_q, y_d;
    logic [LEN_BITS-1:0]  filt_len_q, if3_len_q, if1_len_q, w_q, w_d, len_cur;
    logic [PASS_BITS-1:0] passes_q, pass_q, pass_d;
    logic [ADDR_BITS-1:0] filt_ptr_q, filt_ptr_d, ifmap_ptr_q, ifmap_ptr_d;
    logic [ADDR_BITS-1:0] ipsum_ptr_q, ipsum_ptr_d, opsum_ptr_q, opsum_ptr_d;
    logic [CNT_BITS-1:0]  rd_cnt_q, rd_cnt_d, phase_total;
    logic                 rd_pend_q;
    logic                 feed, start_acc, last_tag, last_pass;
    logic                 stream_ready, stream_valid, pop, opsum_hs, hs, rd_issue;
    logic                 skid_empty;
    logic [1:0]           skid_count;
    logic [2:0]           credit_used;
    logic [DATA_BITS-1:0] skid_head;

    glb_rd_skid #(
        .WIDTH(DATA_BITS)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .push_i (rd_pend_q),
        .pop_i  (pop),
        .data_i (mem_rd_data),
        .empty_o(skid_empty),
        .count_o(skid_count),
        .head_o (skid_head)
    );

    always_comb begin
        case (state_q)
            StFilt:  len_cur = filt_len_q;
            StIf3:   len_cur = if3_len_q;
            StIf1:   len_cur = if1_len_q;
            default: len_cur = LEN_BITS'(1);
        endcase
        case (state_q)
            StFilt:       stream_ready = filter_ready;
            StIf3, StIf1: stream_ready = ifmap_ready;
            StIp:         stream_ready = ipsum_ready;
            default:      stream_ready = 1'b0;
        endcase
    end

    assign feed         = is_feed(state_q);
    assign start_acc    = (state_q == StIdle) && start;
    assign phase_total  = CNT_BITS'(x_num_q) * CNT_BITS'(y_num_q) * CNT_BITS'(len_cur);
    assign last_tag     = (x_q == x_num_q - XID_BITS'(1)) && (y_q == y_num_q - YID_BITS'(1))
                          && (w_q == len_cur - LEN_BITS'(1));
    assign last_pass    = (pass_q == passes_q - PASS_BITS'(1));
    assign stream_valid = feed && !skid_empty;
    assign pop          = stream_valid && stream_ready;
    assign opsum_hs     = (state_q == StOp) && opsum_valid;
    assign hs           = pop || opsum_hs;
    // A head pop this cycle frees a slot, which keeps the stream at one word per cycle.
    assign credit_used  = 3'(skid_count) + 3'(rd_pend_q) - 3'(pop);
    assign rd_issue     = feed && (rd_cnt_q != phase_total) && (credit_used < 3'd2);

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        w_d         = w_q;
        pass_d      = pass_q;
        rd_cnt_d    = rd_issue ? rd_cnt_q + CNT_BITS'(1) : rd_cnt_q;
        filt_ptr_d  = filt_ptr_q;
        ifmap_ptr_d = ifmap_ptr_q;
        ipsum_ptr_d = ipsum_ptr_q;
        opsum_ptr_d = opsum_hs ? opsum_ptr_q + ADDR_BITS'(1) : opsum_ptr_q;
        if (rd_issue) begin
            case (state_q)
                StFilt:       filt_ptr_d  = filt_ptr_q + ADDR_BITS'(1);
                StIf3, StIf1: ifmap_ptr_d = ifmap_ptr_q + ADDR_BITS'(1);
                StIp:         ipsum_ptr_d = ipsum_ptr_q + ADDR_BITS'(1);
                default:      ;
            endcase
        end
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StFilt;
                    x_d         = '0;
                    y_d         = '0;
                    w_d         = '0;
                    pass_d      = '0;
                    rd_cnt_d    = '0;
                    filt_ptr_d  = cfg_filt_base;
                    ifmap_ptr_d = cfg_ifmap_base;
                    ipsum_ptr_d = cfg_ipsum_base;
                    opsum_ptr_d = cfg_opsum_base;
                end
            end
            StFin: state_d = StIdle;
            default: begin
                if (hs && last_tag) begin
                    x_d      = '0;
                    y_d      = '0;
                    w_d      = '0;
                    rd_cnt_d = '0;
                    case (state_q)
                        StFilt:  state_d = StIf3;
                        StIf3:   state_d = StIp;
                        StIp:    state_d = StOp;
                        StIf1:   state_d = StIp;
                        default: begin
                            if (last_pass) begin
                                state_d = StFin;
                            end else begin
                                state_d = StIf1;
                                pass_d  = pass_q + PASS_BITS'(1);
                            end
                        end
                    endcase
                end else if (hs) begin
                    if (w_q == len_cur - LEN_BITS'(1)) begin
                        w_d = '0;
                        if (x_q == x_num_q - XID_BITS'(1)) begin
                            x_d = '0;
                            y_d = y_q + YID_BITS'(1);
                        end else begin
                            x_d = x_q + XID_BITS'(1);
                        end
                    end else begin
                        w_d = w_q + LEN_BITS'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            x_num_q     <= '0;
            y_num_q     <= '0;
            filt_len_q  <= '0;
            if3_len_q   <= '0;
            if1_len_q   <= '0;
            passes_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            w_q         <= '0;
            pass_q      <= '0;
            rd_cnt_q    <= '0;
            rd_pend_q   <= 1'b0;
            filt_ptr_q  <= '0;
            ifmap_ptr_q <= '0;
            ipsum_ptr_q <= '0;
            opsum_ptr_q <= '0;
        end else begin
            if (start_acc) begin
                x_num_q    <= cfg_tag_x_num;
                y_num_q    <= cfg_tag_y_num;
                filt_len_q <= cfg_filt_len;
                if3_len_q  <= cfg_if3_len;
                if1_len_q  <= cfg_if1_len;
                passes_q   <= cfg_passes;
            end
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            w_q         <= w_d;
            pass_q      <= pass_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_pend_q   <= rd_issue;
            filt_ptr_q  <= filt_ptr_d;
            ifmap_ptr_q <= ifmap_ptr_d;
            ipsum_ptr_q <= ipsum_ptr_d;
            opsum_ptr_q <= opsum_ptr_d;
        end
    end

    always_comb begin
        busy          = (state_q != StIdle);
        done          = (state_q == StFin);
        mem_rd_en     = rd_issue;
        mem_rd_addr   = '0;
        if (rd_issue) begin
            case (state_q)
                StFilt:       mem_rd_addr = filt_ptr_q;
                StIf3, StIf1: mem_rd_addr = ifmap_ptr_q;
                default:      mem_rd_addr = ipsum_ptr_q;
            endcase
        end
        mem_wr_en     = opsum_hs;
        mem_wr_addr   = opsum_hs ? opsum_ptr_q : '0;
        mem_wr_data   = opsum_hs ? pe_data_in : '0;
        pe_data_out   = skid_head;
        filter_valid  = stream_valid && (state_q == StFilt);
        ifmap_valid   = stream_valid && ((state_q == StIf3) || (state_q == StIf1));
        ipsum_valid   = stream_valid && (state_q == StIp);
        opsum_ready   = (state_q == StOp);
        filter_tag_X  = (state_q == StFilt) ? x_q : '0;
        filter_tag_Y  = (state_q == StFilt) ? y_q : '0;
        ifmap_tag_X   = ((state_q == StIf3) || (state_q == StIf1)) ? x_q : '0;
        ifmap_tag_Y   = ((state_q == StIf3) || (state_q == StIf1)) ? y_q : '0;
        ipsum_tag_X   = (state_q == StIp) ? x_q : '0;
        ipsum_tag_Y   = (state_q == StIp) ? y_q : '0;
        opsum_tag_X   = opsum_ready ? x_q : '0;
        opsum_tag_Y   = opsum_ready ? y_q : '0;
        ker_feed_done = filter_valid && last_tag;
        if3_feed_done = ifmap_valid && (state_q == StIf3) && last_tag;
        if1_feed_done = ifmap_valid && (state_q == StIf1) && last_tag;
        ip_feed_done  = ipsum_valid && last_tag;
        op_get_done   = opsum_ready && last_tag;
        op_pass_done  = op_get_done && last_pass;
    end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Randomised bench: expected transfers per run are listed up front from the tag-walk rules
// and consumed as the array-side handshakes happen.
module tb_pe_array_feeder;

    localparam int unsigned DW = 16;
    localparam int unsigned XW = 5;
    localparam int unsigned YW = 5;
    localparam int unsigned AW = 14;
    localparam int unsigned LW = 8;
    localparam int unsigned PW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done;
    logic [XW-1:0] cfg_tag_x_num = '0;
    logic [YW-1:0] cfg_tag_y_num = '0;
    logic [LW-1:0] cfg_filt_len = '0, cfg_if3_len = '0, cfg_if1_len = '0;
    logic [PW-1:0] cfg_passes = '0;
    logic [AW-1:0] cfg_filt_base = '0, cfg_ifmap_base = '0, cfg_ipsum_base = '0;
    logic [AW-1:0] cfg_opsum_base = '0;
    logic          mem_rd_en, mem_wr_en;
    logic [AW-1:0] mem_rd_addr, mem_wr_addr;
    logic [DW-1:0] mem_rd_data, mem_wr_data, pe_data_out;
    logic [DW-1:0] pe_data_in = '0;
    logic          filter_valid, ifmap_valid, ipsum_valid, opsum_ready;
    logic          filter_ready = 1'b0, ifmap_ready = 1'b0, ipsum_ready = 1'b0;
    logic          opsum_valid = 1'b0;
    logic [XW-1:0] filter_tag_X, ifmap_tag_X, ipsum_tag_X, opsum_tag_X;
    logic [YW-1:0] filter_tag_Y, ifmap_tag_Y, ipsum_tag_Y, opsum_tag_Y;
    logic          ker_feed_done, if3_feed_done, ip_feed_done, if1_feed_done;
    logic          op_get_done, op_pass_done;

    always #5 clk = ~clk;

    pe_array_feeder #(
        .DATA_BITS(DW), .XID_BITS(XW), .YID_BITS(YW),
        .ADDR_BITS(AW), .LEN_BITS(LW), .PASS_BITS(PW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .cfg_tag_x_num(cfg_tag_x_num), .cfg_tag_y_num(cfg_tag_y_num),
        .cfg_filt_len(cfg_filt_len), .cfg_if3_len(cfg_if3_len), .cfg_if1_len(cfg_if1_len),
        .cfg_passes(cfg_passes), .cfg_filt_base(cfg_filt_base),
        .cfg_ifmap_base(cfg_ifmap_base), .cfg_ipsum_base(cfg_ipsum_base),
        .cfg_opsum_base(cfg_opsum_base),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .pe_data_out(pe_data_out),
        .filter_valid(filter_valid), .filter_ready(filter_ready),
        .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
        .ipsum_valid(ipsum_valid), .ipsum_ready(ipsum_ready),
        .opsum_ready(opsum_ready), .opsum_valid(opsum_valid), .pe_data_in(pe_data_in),
        .filter_tag_X(filter_tag_X), .ifmap_tag_X(ifmap_tag_X),
        .ipsum_tag_X(ipsum_tag_X), .opsum_tag_X(opsum_tag_X),
        .filter_tag_Y(filter_tag_Y), .ifmap_tag_Y(ifmap_tag_Y),
        .ipsum_tag_Y(ipsum_tag_Y), .opsum_tag_Y(opsum_tag_Y),
        .ker_feed_done(ker_feed_done), .if3_feed_done(if3_feed_done),
        .ip_feed_done(ip_feed_done), .if1_feed_done(if1_feed_done),
        .op_get_done(op_get_done), .op_pass_done(op_pass_done)
    );

    logic [DW-1:0] sram [2**AW];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= sram[mem_rd_addr];

    // ph: 0 FILT, 1 IF3, 2 IP, 3 OP, 4 IF1
    typedef struct {
        int            ph;
        logic [DW-1:0] data;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        bit            last;
        bit            plast;
    } item_t;

    item_t         exq[$];
    logic [AW-1:0] rdq[$];
    logic [AW-1:0] op_addr;
    int            vectors = 0, miscompares = 0;
    int            rd_issued = 0, fed = 0, done_seen = 0, cyc_cnt = 0;
    bit            run_active = 0, exp_done_next = 0, stall_prev = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int stream_of(input int ph);
        return (ph == 4) ? 1 : ph;
    endfunction

    task automatic add_phase(input int ph, input int nx, input int ny, input int len,
                             inout logic [AW-1:0] ptr, input bit plast);
        item_t it;
        for (int y = 0; y < ny; y++)
            for (int x = 0; x < nx; x++)
                for (int w = 0; w < len; w++) begin
                    it.ph    = ph;
                    it.x     = XW'(x);
                    it.y     = YW'(y);
                    it.last  = (y == ny - 1) && (x == nx - 1) && (w == len - 1);
                    it.plast = plast;
                    it.data  = '0;
                    if (ph != 3) begin
                        it.data = sram[ptr];
                        rdq.push_back(ptr);
                        ptr = ptr + AW'(1);
                    end
                    exq.push_back(it);
                end
    endtask

    task automatic clear_model();
        exq.delete();
        rdq.delete();
        rd_issued     = 0;
        fed           = 0;
        run_active    = 0;
        exp_done_next = 0;
        stall_prev    = 0;
    endtask

    task automatic cycle(input bit st, input int pct);
        logic [2:0] vs;
        item_t      h;
        bit         have, act, hs, opw;
        int         strm;
        @(negedge clk);
        cyc_cnt++;
        start = st;
        if (pct < 0) begin
            filter_ready = (cyc_cnt % 4 == 0) || (cyc_cnt % 4 == 3);
            ifmap_ready  = filter_ready;
            ipsum_ready  = filter_ready;
            opsum_valid  = filter_ready;
        end else begin
            filter_ready = ($urandom_range(99) < pct);
            ifmap_ready  = ($urandom_range(99) < pct);
            ipsum_ready  = ($urandom_range(99) < pct);
            opsum_valid  = ($urandom_range(99) < pct);
        end
        pe_data_in = DW'($urandom);
        #1;
        have = (exq.size() > 0);
        if (have) h = exq[0];
        act  = run_active;
        strm = (act && have) ? stream_of(h.ph) : -1;
        chk("busy", busy, act);
        chk("done", done, exp_done_next);
        if (done) done_seen++;
        vs = {filter_valid, ifmap_valid, ipsum_valid};
        chk("valid_onehot", $countones(vs) <= 1, 1);
        if (stall_prev) chk("valid_hold", |vs, 1);
        if (|vs) begin
            chk("valid_stream", filter_valid ? 0 : (ifmap_valid ? 1 : 2), strm);
            if (have) chk("pe_data", pe_data_out, h.data);
        end else begin
            chk("pe_data_idle", pe_data_out, 0);
        end
        chk("filter_tag", {filter_tag_Y, filter_tag_X}, (strm == 0) ? {h.y, h.x} : '0);
        chk("ifmap_tag", {ifmap_tag_Y, ifmap_tag_X}, (strm == 1) ? {h.y, h.x} : '0);
        chk("ipsum_tag", {ipsum_tag_Y, ipsum_tag_X}, (strm == 2) ? {h.y, h.x} : '0);
        chk("opsum_tag", {opsum_tag_Y, opsum_tag_X}, (strm == 3) ? {h.y, h.x} : '0);
        chk("ker_feed_done", ker_feed_done, filter_valid && strm == 0 && h.last);
        chk("if3_feed_done", if3_feed_done, ifmap_valid && strm == 1 && h.ph == 1 && h.last);
        chk("if1_feed_done", if1_feed_done, ifmap_valid && strm == 1 && h.ph == 4 && h.last);
        chk("ip_feed_done", ip_feed_done, ipsum_valid && strm == 2 && h.last);
        chk("opsum_ready", opsum_ready, strm == 3);
        chk("op_get_done", op_get_done, strm == 3 && h.last);
        chk("op_pass_done", op_pass_done, strm == 3 && h.last && h.plast);
        opw = (strm == 3) && opsum_valid;
        chk("wr_en", mem_wr_en, opw);
        if (opw) begin
            chk("wr_addr", mem_wr_addr, op_addr);
            chk("wr_data", mem_wr_data, pe_data_in);
        end
        if (mem_rd_en) begin
            if (rdq.size() == 0) begin
                chk("rd_extra", mem_rd_en, 0);
            end else begin
                chk("rd_addr", mem_rd_addr, rdq[0]);
                rdq.delete(0);
                rd_issued++;
            end
        end
        case (strm)
            0:       hs = filter_valid && filter_ready;
            1:       hs = ifmap_valid && ifmap_ready;
            2:       hs = ipsum_valid && ipsum_ready;
            3:       hs = opsum_valid;
            default: hs = 0;
        endcase
        if (hs) begin
            exq.delete(0);
            if (strm == 3) op_addr = op_addr + AW'(1);
            else fed++;
        end
        chk("outstanding", (rd_issued - fed) <= 2, 1);
        stall_prev = (|vs) && !hs;
        if (exp_done_next) run_active = 0;
        exp_done_next = hs && strm == 3 && h.last && h.plast;
        if (st && !act) run_active = 1;
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        #1;
        chk({tag, "_ctrl"}, {busy, done, mem_rd_en, mem_wr_en, filter_valid, ifmap_valid,
             ipsum_valid, opsum_ready, ker_feed_done, if3_feed_done, ip_feed_done,
             if1_feed_done, op_get_done, op_pass_done}, 0);
        chk({tag, "_addr"}, {mem_rd_addr, mem_wr_addr}, 0);
        chk({tag, "_data"}, {mem_wr_data, pe_data_out}, 0);
        chk({tag, "_tag_fi"}, {filter_tag_Y, filter_tag_X, ifmap_tag_Y, ifmap_tag_X}, 0);
        chk({tag, "_tag_po"}, {ipsum_tag_Y, ipsum_tag_X, opsum_tag_Y, opsum_tag_X}, 0);
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int nx, input int ny, input int fl, input int i3, input int i1,
                       input int np, input logic [AW-1:0] fb, input logic [AW-1:0] ib,
                       input logic [AW-1:0] pb, input logic [AW-1:0] ob, input int pct,
                       input int inj_at, input bit rst_if3);
        logic [AW-1:0] fp = fb, ip = ib, pp = pb, dummy = '0;
        int n = 0, if3_cyc = 0;
        cfg_tag_x_num = XW'(nx);  cfg_tag_y_num = YW'(ny);
        cfg_filt_len  = LW'(fl);  cfg_if3_len   = LW'(i3);
        cfg_if1_len   = LW'(i1);  cfg_passes    = PW'(np);
        cfg_filt_base = fb; cfg_ifmap_base = ib; cfg_ipsum_base = pb; cfg_opsum_base = ob;
        clear_model();
        op_addr = ob;
        add_phase(0, nx, ny, fl, fp, 0);
        add_phase(1, nx, ny, i3, ip, 0);
        for (int p = 0; p < np; p++) begin
            add_phase(2, nx, ny, 1, pp, 0);
            add_phase(3, nx, ny, 1, dummy, p == np - 1);
            if (p < np - 1) add_phase(4, nx, ny, i1, ip, 0);
        end
        done_seen = 0;
        cycle(1, pct);
        while (run_active && n < 3000) begin
            if (n == inj_at) begin
                cfg_tag_x_num  = XW'($urandom_range(1, 3));
                cfg_filt_len   = LW'($urandom_range(1, 3));
                cfg_filt_base  = AW'($urandom);
                cfg_opsum_base = AW'($urandom);
            end
            cycle(n == inj_at, pct);
            n++;
            if (rst_if3 && exq.size() > 0 && exq[0].ph == 1) begin
                if3_cyc++;
                if (if3_cyc == 3) begin
                    apply_reset("rst_if3");
                    return;
                end
            end
        end
        if (run_active) begin
            chk("timeout_busy", busy, 0);
            apply_reset("timeout");
        end else begin
            chk("items_left", exq.size(), 0);
            chk("done_count", done_seen, 1);
            cycle(0, pct);
        end
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++) sram[i] = DW'($urandom);
        apply_reset("reset");
        run(2, 1, 3, 2, 1, 2, 14'h0100, 14'h0800, 14'h1000, 14'h2000, 100, -1, 0);
        run(2, 1, 3, 2, 1, 1, 14'h0200, 14'h0900, 14'h1100, 14'h2100, -1, -1, 0);
        run(2, 2, 2, 3, 2, 2, AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
            50, -1, 0);
        run(1, 1, 1, 2, 1, 1, 14'h0040, 14'h3FFF, 14'h0400, 14'h0600, 100, -1, 0);
        run(3, 2, 2, 2, 1, 2, AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
            60, -1, 1);
        run(2, 1, 2, 2, 1, 2, AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
            100, -1, 0);
        run(2, 2, 1, 1, 1, 3, AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
            70, 10, 0);
        for (int r = 0; r < 4; r++) begin
            run($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 4),
                $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(1, 3),
                AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
                $urandom_range(30, 100), -1, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
